// File: rtl/hazard_ctrl_if.sv
// Decode/execute/writeback side-band bundle seen by the hazard controller.
// master = pipeline driving requests, slave = hazard_ctrl.
interface hazard_ctrl_if;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_use;
    logic        rs2_use;
    logic [4:0]  rd;
    logic        rd_load;
    logic        branch;
    logic [31:0] target;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] pending;

    modport master (
        output issue_valid, rs1, rs2, rs1_use, rs2_use, rd, rd_load,
        output branch, target, retire_valid, retire_rd,
        input  issue_ready, redirect, redirect_pc, flush, pending
    );

    modport slave (
        input  issue_valid, rs1, rs2, rs1_use, rs2_use, rd, rd_load,
        input  branch, target, retire_valid, retire_rd,
        output issue_ready, redirect, redirect_pc, flush, pending
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use scoreboard plus branch redirect/flush sequencer.
// Outputs are combinational from registered state and current inputs.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic          aclk,
    input logic          aresetn,
    hazard_ctrl_if.slave hz
);

    typedef enum logic {
        RUN,
        FLUSH
    } state_e;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pending_q, pending_d;

    logic in_run;
    logic hazard;
    logic fire;

    always_comb begin
        in_run = (state_q == RUN);
        hazard = (hz.rs1_use & pending_q[hz.rs1] & (hz.rs1 != 5'd0))
               | (hz.rs2_use & pending_q[hz.rs2] & (hz.rs2 != 5'd0));

        hz.issue_ready = in_run & ~hz.branch & ~hazard;
        hz.redirect    = in_run & hz.branch;
        hz.redirect_pc = hz.target;
        hz.flush       = (state_q == FLUSH);
        hz.pending     = pending_q;

        fire = hz.issue_valid & hz.issue_ready;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (hz.branch) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_INIT;
                end
            end
            FLUSH: begin
                if (cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Clear before set so an issuing load wins over a same-cycle retire.
    always_comb begin
        pending_d = pending_q;
        if (hz.retire_valid) begin
            pending_d[hz.retire_rd] = 1'b0;
        end
        if (fire && hz.rd_load) begin
            pending_d[hz.rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= RUN;
            cnt_q     <= 3'd0;
            pending_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table vectors, corner sequences and random traffic for hazard_ctrl,
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int FC = 2;

    logic aclk;
    logic aresetn;

    hazard_ctrl_if bus ();

    hazard_ctrl #(
        .FLUSH_CYCLES(FC)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .hz     (bus.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: set of outstanding load destinations and flush cycles left.
    bit [31:0] m_pend;
    int        m_left;

    function automatic bit m_hazard();
        bit h1, h2;
        h1 = bus.rs1_use && m_pend[bus.rs1] && bus.rs1 != 0;
        h2 = bus.rs2_use && m_pend[bus.rs2] && bus.rs2 != 0;
        return h1 || h2;
    endfunction

    function automatic bit m_ready();
        return (m_left == 0) && !bus.branch && !m_hazard();
    endfunction

    function automatic bit [31:0] m_next_pend();
        bit [31:0] p;
        p = m_pend;
        if (bus.retire_valid) p[bus.retire_rd] = 1'b0;
        if (bus.issue_valid && m_ready() && bus.rd_load) p[bus.rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    always @(posedge aclk) begin
        if (!aresetn) begin
            m_pend <= 32'd0;
            m_left <= 0;
        end else begin
            m_pend <= m_next_pend();
            if (m_left > 0)      m_left <= m_left - 1;
            else if (bus.branch) m_left <= FC;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit exp_redir;
        exp_redir = (m_left == 0) && bus.branch;
        check("m_ready", 32'(bus.issue_ready), 32'(m_ready()));
        check("m_redirect", 32'(bus.redirect), 32'(exp_redir));
        check("m_flush", 32'(bus.flush), 32'(m_left > 0));
        check("m_pending", bus.pending, m_pend);
        if (exp_redir) check("m_redirect_pc", bus.redirect_pc, bus.target);
    endtask

    typedef struct {
        logic        rstn;
        logic        v;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        ld;
        logic        br;
        logic [31:0] tgt;
        logic        rv;
        logic [4:0]  rrd;
        logic        e_rdy;
        logic        e_redir;
        logic        e_flush;
        logic [31:0] e_pend;
    } vec_t;

    vec_t tbl[16];

    task automatic drive(input vec_t t);
        aresetn          = t.rstn;
        bus.issue_valid  = t.v;
        bus.rs1          = t.rs1;
        bus.rs1_use      = t.u1;
        bus.rs2          = t.rs2;
        bus.rs2_use      = t.u2;
        bus.rd           = t.rd;
        bus.rd_load      = t.ld;
        bus.branch       = t.br;
        bus.target       = t.tgt;
        bus.retire_valid = t.rv;
        bus.retire_rd    = t.rrd;
    endtask

    task automatic idle();
        vec_t z;
        z = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
              1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0};
        drive(z);
    endtask

    initial begin
        //        rst v  rs1 u1 rs2 u2 rd ld br tgt       rv rrd  rdy rd fl pend
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0,  1, 0, 0, 32'h00};
        tbl[1]  = '{1, 1, 0, 0, 0, 0, 5, 1, 0, 32'h0,   0, 0,  1, 0, 0, 32'h00};
        tbl[2]  = '{1, 1, 5, 1, 0, 0, 0, 0, 0, 32'h0,   0, 0,  0, 0, 0, 32'h20};
        tbl[3]  = '{1, 1, 5, 1, 0, 0, 0, 0, 0, 32'h0,   1, 5,  0, 0, 0, 32'h20};
        tbl[4]  = '{1, 1, 5, 1, 0, 0, 0, 0, 0, 32'h0,   0, 0,  1, 0, 0, 32'h00};
        tbl[5]  = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0,   0, 0,  1, 0, 0, 32'h00};
        tbl[6]  = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0,   0, 0,  1, 0, 0, 32'h00};
        tbl[7]  = '{1, 1, 0, 0, 0, 0, 7, 1, 0, 32'h0,   1, 7,  1, 0, 0, 32'h00};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0,  1, 0, 0, 32'h80};
        tbl[9]  = '{1, 1, 0, 0, 0, 0, 3, 1, 0, 32'h0,   0, 0,  1, 0, 0, 32'h80};
        tbl[10] = '{1, 1, 0, 0, 0, 0, 9, 1, 1, 32'h100, 0, 0,  0, 1, 0, 32'h88};
        tbl[11] = '{1, 1, 0, 0, 0, 0,10, 1, 1, 32'h200, 1, 3,  0, 0, 1, 32'h88};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0,  0, 0, 1, 32'h80};
        tbl[13] = '{1, 1, 0, 0, 7, 1, 0, 0, 0, 32'h0,   1, 7,  0, 0, 0, 32'h80};
        tbl[14] = '{1, 1, 0, 0, 7, 1, 0, 0, 0, 32'h0,   0, 0,  1, 0, 0, 32'h00};
        tbl[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0,  1, 0, 0, 32'h00};

        idle();
        aresetn = 1'b0;
        @(posedge aclk);
        @(posedge aclk);
        @(negedge aclk);

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            check($sformatf("t%0d_ready", i), 32'(bus.issue_ready), 32'(tbl[i].e_rdy));
            check($sformatf("t%0d_redirect", i), 32'(bus.redirect), 32'(tbl[i].e_redir));
            check($sformatf("t%0d_flush", i), 32'(bus.flush), 32'(tbl[i].e_flush));
            check($sformatf("t%0d_pending", i), bus.pending, tbl[i].e_pend);
            if (tbl[i].e_redir) begin
                check($sformatf("t%0d_pc", i), bus.redirect_pc, tbl[i].tgt);
            end
            @(negedge aclk);
        end

        // Fill every scoreboard bit, enter FLUSH, then reset mid-flush.
        for (int r = 1; r < 32; r++) begin
            idle();
            bus.issue_valid = 1'b1;
            bus.rd_load     = 1'b1;
            bus.rd          = 5'(r);
            #1;
            check_model();
            @(negedge aclk);
        end
        idle();
        bus.branch = 1'b1;
        bus.target = 32'hdead_beef;
        #1;
        check("seq_redirect", 32'(bus.redirect), 32'd1);
        check("seq_redirect_pc", bus.redirect_pc, 32'hdead_beef);
        @(negedge aclk);
        idle();
        #1;
        check("seq_flush_pre", 32'(bus.flush), 32'd1);
        check("seq_pend_full", bus.pending, 32'hffff_fffe);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("seq_flush_post", 32'(bus.flush), 32'd0);
        check("seq_pend_post", bus.pending, 32'd0);
        check("seq_ready_post", 32'(bus.issue_ready), 32'd1);
        @(negedge aclk);

        for (int c = 0; c < 3000; c++) begin
            aresetn          = ($urandom_range(0, 99) != 0);
            bus.issue_valid  = $urandom_range(0, 1) == 1;
            bus.rs1          = 5'($urandom_range(0, 7));
            bus.rs2          = 5'($urandom_range(0, 7));
            bus.rs1_use      = $urandom_range(0, 1) == 1;
            bus.rs2_use      = $urandom_range(0, 1) == 1;
            bus.rd           = 5'($urandom_range(0, 7));
            bus.rd_load      = $urandom_range(0, 1) == 1;
            bus.branch       = ($urandom_range(0, 7) == 0);
            bus.target       = $urandom;
            bus.retire_valid = ($urandom_range(0, 2) == 0);
            bus.retire_rd    = 5'($urandom_range(0, 7));
            #1;
            check_model();
            @(negedge aclk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, legal 1..7: number of cycles younger pipeline stages are squashed after a taken branch.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 aclk  in  1  clock; all state updates on its rising edge.
REQ-004 aresetn  in  1  synchronous active-low reset.
REQ-005 issue_valid  in  1  decode presents an instruction.
REQ-006 issue_ready  out  1  instruction may advance to execute; handshake = issue_valid & issue_ready.
REQ-007 rs1, rs2  in  5 each  source register addresses.
REQ-008 rs1_use, rs2_use  in  1 each  source actually read by the instruction.
REQ-009 rd  in  5  destination register address.
REQ-010 rd_load  in  1  instruction is a load writing rd.
REQ-011 branch  in  1  execute stage resolved a taken branch or jump this cycle.
REQ-012 target  in  32  branch/jump destination address.
REQ-013 retire_valid  in  1  writeback commits a load result this cycle.
REQ-014 retire_rd  in  5  register committed by writeback.
REQ-015 redirect  out  1  fetch shall load redirect_pc.
REQ-016 redirect_pc  out  32  new fetch address.
REQ-017 flush  out  1  fetch/decode contents are wrong-path and shall be discarded.
REQ-018 pending  out  32  load scoreboard; bit n set = load to xn outstanding.

Function
REQ-019 States: RUN, FLUSH; a 3-bit down-counter cnt is used in FLUSH.
REQ-020 In RUN, branch=1 SHALL assert redirect=1 combinationally that same cycle with redirect_pc=target; next state FLUSH, cnt loaded with FLUSH_CYCLES-1.
REQ-021 In RUN, branch=0: redirect=0, redirect_pc=target (don't-care), state held.
REQ-022 In FLUSH: flush=1, redirect=0, branch ignored; cnt decrements each cycle; at cnt=0 next state RUN.
REQ-023 flush SHALL be 1 for exactly FLUSH_CYCLES consecutive cycles after the branch cycle and 0 in RUN.
REQ-024 hazard = (rs1_use & pending[rs1] & rs1!=0) | (rs2_use & pending[rs2] & rs2!=0).
REQ-025 issue_ready SHALL = (state==RUN) & ~branch & ~hazard; independent of issue_valid.
REQ-026 Scoreboard uses registered pending only; a retire in the same cycle does not release a stall until the next cycle.
REQ-027 On handshake with rd_load=1 and rd!=0, pending[rd] SHALL be set next cycle.
REQ-028 On retire_valid=1, pending[retire_rd] SHALL be cleared next cycle; retire_rd=0 has no effect.
REQ-029 Simultaneous set and clear of the same bit: set wins.
REQ-030 pending[0] SHALL always be 0.
REQ-031 Retires SHALL be processed in every state, including FLUSH.
REQ-032 No handshake can occur in FLUSH or on a branch cycle, so wrong-path loads never set scoreboard bits.
REQ-033 Non-load instructions and rd_load with rd=0 SHALL not change pending.

Reset
REQ-034 While aresetn=0 at a clock edge: state=RUN, cnt=0, pending=0.
REQ-035 After reset: flush=0, redirect=0, issue_ready=~branch.
REQ-036 Reset asserted mid-FLUSH SHALL abort the flush; flush=0 the cycle after the reset edge.
REQ-037 Outputs are combinational from state and inputs; no output register other than pending.

Verification
REQ-038 Load issued, rd=5 -> pending=0x20 next cycle; following instr rs1=5 rs1_use=1 -> issue_ready=0 until cycle after retire_valid=1 retire_rd=5, then 1.
REQ-039 branch=1 target=0x100 in RUN, FLUSH_CYCLES=2 -> redirect=1 redirect_pc=0x100 that cycle; flush=1 next 2 cycles; issue_ready=0 for 3 cycles; then RUN.
REQ-040 Load rd=0 issued -> pending stays 0; instr rs1=0 never stalls.
REQ-041 Same cycle: load handshake rd=7 and retire_rd=7 -> pending[7]=1 next cycle.
REQ-042 Retire rd=3 during FLUSH with pending[3]=1 -> pending[3]=0 next cycle; branch pulse during FLUSH -> no redirect, flush length unchanged.
REQ-043 aresetn=0 for one cycle mid-FLUSH with pending=0xFFFF_FFFE -> next cycle state RUN, flush=0, pending=0.
